// File: rtl/fpa_pkg.sv
// Shared constants and types for the floating-point adder back end.
package fpa_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int GRS_W   = 3;

   // Raw sum width: carry + hidden + fraction + guard/round/sticky
   localparam int RAW_W   = MAN_W + GRS_W + 2;
   // Normalised mantissa width: hidden + fraction + guard/round/sticky
   localparam int NRM_W   = MAN_W + GRS_W + 1;

   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [RAW_W-1:0] mant;
   } raw_sum_t;

endpackage

// File: rtl/fpa_lzc.sv
// Leading-zero counter for the 27-bit hidden/fraction/GRS field.
// An all-zero input reports 27.
module fpa_lzc
   import fpa_pkg::*;
(
   input  logic [NRM_W-1:0] data_i,
   output logic [4:0]       count_o
);

   // Scan from LSB upward so the most significant set bit has the final say
   always_comb begin
      count_o = 5'd27;
      for (int i = 0; i < NRM_W; i++) begin
         if (data_i[i]) begin
            count_o = 5'(NRM_W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fpa_normalize_round.sv
// Normalise and round-to-nearest-even the raw adder sum, then pack it as an
// IEEE-754 single. Two pipeline stages with valid/ready on both sides.
module fpa_normalize_round
   import fpa_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [RAW_W-1:0] in_mant,
   input  logic             in_special,
   input  logic [31:0]      in_special_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data
);

   raw_sum_t         rawIn;

   logic             s1Valid_q;
   logic             s1Sign_q;
   logic [EXP_W:0]   s1Exp_q;
   logic [NRM_W-1:0] s1Mant_q;
   logic             s1Zero_q;
   logic             s1Special_q;
   logic [31:0]      s1Word_q;

   logic [EXP_W:0]   s1Exp_d;
   logic [NRM_W-1:0] s1Mant_d;
   logic             s1Zero_d;

   logic             outValid_q;
   logic [31:0]      outData_q;
   logic [31:0]      outData_d;

   logic             s1Adv;
   logic             s2Adv;

   logic [4:0]       lzcCount;
   logic [EXP_W:0]   maxShift;
   logic [EXP_W:0]   shiftAmt;
   logic [NRM_W-1:0] shifted;

   logic             roundUp;
   logic [24:0]      roundSum;
   logic [EXP_W:0]   roundExp;
   logic [MAN_W-1:0] roundFrac;

   assign rawIn = {in_sign, in_exp, in_mant};

   assign s2Adv     = !outValid_q || out_ready;
   assign s1Adv     = !s1Valid_q || s2Adv;
   assign in_ready  = s1Adv;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;

   fpa_lzc uLzc (
      .data_i  (rawIn.mant[NRM_W-1:0]),
      .count_o (lzcCount)
   );

   // Stage 1: bring the leading one into the hidden position, or stop at exponent 1
   always_comb begin
      s1Exp_d  = '0;
      s1Mant_d = '0;
      s1Zero_d = 1'b0;
      maxShift = '0;
      shiftAmt = '0;
      shifted  = '0;
      if (rawIn.mant[RAW_W-1]) begin
         s1Mant_d = {rawIn.mant[RAW_W-1:2], rawIn.mant[1] | rawIn.mant[0]};
         s1Exp_d  = {1'b0, rawIn.exp} + 9'd1;
      end else if (rawIn.mant == '0) begin
         s1Zero_d = 1'b1;
      end else begin
         maxShift = (rawIn.exp == '0) ? 9'd0 : {1'b0, rawIn.exp} - 9'd1;
         shiftAmt = ({4'd0, lzcCount} < maxShift) ? {4'd0, lzcCount} : maxShift;
         shifted  = rawIn.mant[NRM_W-1:0] << shiftAmt;
         s1Mant_d = shifted;
         s1Exp_d  = {1'b0, rawIn.exp} - shiftAmt;
         if (!shifted[NRM_W-1]) begin
            s1Exp_d = '0;
         end
      end
   end

   // Stage 1 register: loads whenever the stage can advance, holds on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q   <= 1'b0;
         s1Sign_q    <= 1'b0;
         s1Exp_q     <= '0;
         s1Mant_q    <= '0;
         s1Zero_q    <= 1'b0;
         s1Special_q <= 1'b0;
         s1Word_q    <= '0;
      end else if (s1Adv) begin
         s1Valid_q <= in_valid;
         if (in_valid) begin
            s1Sign_q    <= rawIn.sign;
            s1Exp_q     <= s1Exp_d;
            s1Mant_q    <= s1Mant_d;
            s1Zero_q    <= s1Zero_d;
            s1Special_q <= in_special;
            s1Word_q    <= in_special_word;
         end
      end
   end

   // Stage 2: round to nearest even, fix up exponent on carry, saturate to infinity
   always_comb begin
      roundUp   = s1Mant_q[2] & (s1Mant_q[1] | s1Mant_q[0] | s1Mant_q[3]);
      roundSum  = {1'b0, s1Mant_q[NRM_W-1:GRS_W]} + {24'd0, roundUp};
      roundExp  = s1Exp_q;
      roundFrac = roundSum[MAN_W-1:0];
      if (roundSum[24]) begin
         roundExp  = s1Exp_q + 9'd1;
         roundFrac = '0;
      end else if ((s1Exp_q == '0) && roundSum[23]) begin
         roundExp = 9'd1;
      end
      if (s1Special_q) begin
         outData_d = s1Word_q;
      end else if (s1Zero_q) begin
         outData_d = {s1Sign_q, 31'b0};
      end else if (roundExp >= 9'(EXP_MAX)) begin
         outData_d = {s1Sign_q, 8'hFF, 23'h0};
      end else begin
         outData_d = {s1Sign_q, roundExp[EXP_W-1:0], roundFrac};
      end
   end

   // Output register: holds the word steady while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
      end else if (s2Adv) begin
         outValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            outData_q <= outData_d;
         end
      end
   end

endmodule
